l2_req_issue: RTL and testbench

Request issue stage directly downstream of the 16-stream round-robin merge. Takes each merged cache-line request (a stream id) and allocates a command tag from a shared pool, then issues the tagged request towards the OpenCAPI command interface. Retires tags on response and enforces a per-stream outstanding-request limit, which is fed back so the streams stop requesting.

---
 rtl/l2_pkg.sv | 12 +
 rtl/l2_tag_pool.sv | 64 ++++++
 rtl/l2_req_issue.sv | 141 ++++++++++++++
 tb/tb_l2_req_issue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared sizing and types for the L2 request issue stage.
// The defaults here feed the module parameters of the tag pool and the top.
package l2_pkg;
    localparam int WAYS   = 16;
    localparam int TAGS   = 32;
    localparam int MAXOUT = 4;
    localparam int SIDW   = $clog2(WAYS);
    localparam int TAGW   = $clog2(TAGS);

    typedef logic [TAGW-1:0] tag_t;
    typedef logic [SIDW-1:0] sid_t;
endpackage

// File: rtl/l2_tag_pool.sv
// Command tag pool: free bitmap, lowest-free allocation, tag-to-stream table
// and free-tag count.
module l2_tag_pool
    import l2_pkg::*;
#(
    parameter int WAYS = l2_pkg::WAYS,
    parameter int TAGS = l2_pkg::TAGS,
    parameter int SIDW = $clog2(WAYS),
    parameter int TAGW = $clog2(TAGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_alloc,
    input  logic [SIDW-1:0] i_alloc_sid,
    input  logic            i_retire,
    input  logic [TAGW-1:0] i_retire_tag,
    output logic            o_any_free,
    output logic [TAGW-1:0] o_cand,
    output logic            o_retire_inuse,
    output logic [SIDW-1:0] o_retire_sid,
    output logic [TAGW:0]   o_free
);
    logic [TAGS-1:0] r_free;
    logic [SIDW-1:0] r_table [TAGS];

    // Scanning downwards leaves the lowest free index as the final winner.
    always_comb begin
        o_cand = '0;
        for (int t = TAGS - 1; t >= 0; t--) begin
            if (r_free[t]) begin
                o_cand = TAGW'(t);
            end
        end
    end

    always_comb begin
        o_free = '0;
        for (int t = 0; t < TAGS; t++) begin
            o_free = o_free + {{TAGW{1'b0}}, r_free[t]};
        end
    end

    assign o_any_free     = |r_free;
    assign o_retire_inuse = ~r_free[i_retire_tag];
    assign o_retire_sid   = r_table[i_retire_tag];

    // Retire only ever targets an in-use tag, so it never collides with the candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_free <= '1;
            for (int t = 0; t < TAGS; t++) begin
                r_table[t] <= '0;
            end
        end else begin
            if (i_alloc) begin
                r_free[o_cand]  <= 1'b0;
                r_table[o_cand] <= i_alloc_sid;
            end
            if (i_retire) begin
                r_free[i_retire_tag] <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/l2_req_issue.sv
// Request issue stage: tags merged stream requests, enforces per-stream
// outstanding limits and retires tags on response.
module l2_req_issue
    import l2_pkg::*;
#(
    parameter int WAYS   = l2_pkg::WAYS,
    parameter int TAGS   = l2_pkg::TAGS,
    parameter int MAXOUT = l2_pkg::MAXOUT,
    parameter int SIDW   = $clog2(WAYS),
    parameter int TAGW   = $clog2(TAGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_v,
    output logic            i_r,
    input  logic [SIDW-1:0] i_sel,
    output logic            o_v,
    input  logic            o_r,
    output logic [TAGW-1:0] o_tag,
    output logic [SIDW-1:0] o_sid,
    input  logic            rsp_v,
    input  logic [TAGW-1:0] rsp_tag,
    output logic            c_v,
    output logic [SIDW-1:0] c_sid,
    output logic [TAGW-1:0] c_tag,
    output logic [WAYS-1:0] o_busy,
    output logic [TAGW:0]   o_free,
    output logic            o_err
);
    localparam int CNTW = $clog2(MAXOUT + 1);
    localparam logic [CNTW-1:0] MAXC = CNTW'(MAXOUT);

    logic            w_any_free;
    logic [TAGW-1:0] w_cand;
    logic            w_inuse;
    logic [SIDW-1:0] w_rsid;
    logic            w_accept;
    logic            w_retire;
    logic [WAYS-1:0] w_inc;
    logic [WAYS-1:0] w_dec;

    logic [CNTW-1:0] r_cnt [WAYS];
    logic            r_ov;
    logic [TAGW-1:0] r_otag;
    logic [SIDW-1:0] r_osid;
    logic            r_cv;
    logic [SIDW-1:0] r_csid;
    logic [TAGW-1:0] r_ctag;
    logic            r_err;

    l2_tag_pool #(
        .WAYS(WAYS),
        .TAGS(TAGS),
        .SIDW(SIDW),
        .TAGW(TAGW)
    ) u_pool (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_accept),
        .i_alloc_sid   (i_sel),
        .i_retire      (w_retire),
        .i_retire_tag  (rsp_tag),
        .o_any_free    (w_any_free),
        .o_cand        (w_cand),
        .o_retire_inuse(w_inuse),
        .o_retire_sid  (w_rsid),
        .o_free        (o_free)
    );

    assign i_r      = w_any_free & (r_cnt[i_sel] < MAXC) & (~r_ov | o_r);
    assign w_accept = i_v & i_r;
    assign w_retire = rsp_v & w_inuse;

    always_comb begin
        w_inc  = '0;
        w_dec  = '0;
        o_busy = '0;
        for (int s = 0; s < WAYS; s++) begin
            w_inc[s]  = w_accept && (i_sel == SIDW'(s));
            w_dec[s]  = w_retire && (w_rsid == SIDW'(s));
            o_busy[s] = (r_cnt[s] == MAXC);
        end
    end

    // A stream that both issues and retires in one cycle keeps its count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < WAYS; s++) begin
                r_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < WAYS; s++) begin
                if (w_inc[s] && !w_dec[s]) begin
                    r_cnt[s] <= r_cnt[s] + CNTW'(1);
                end else if (w_dec[s] && !w_inc[s]) begin
                    r_cnt[s] <= r_cnt[s] - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ov   <= 1'b0;
            r_otag <= '0;
            r_osid <= '0;
        end else if (w_accept) begin
            r_ov   <= 1'b1;
            r_otag <= w_cand;
            r_osid <= i_sel;
        end else if (o_r) begin
            r_ov   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cv   <= 1'b0;
            r_csid <= '0;
            r_ctag <= '0;
            r_err  <= 1'b0;
        end else begin
            r_cv <= w_retire;
            if (w_retire) begin
                r_csid <= w_rsid;
                r_ctag <= rsp_tag;
            end
            if (rsp_v && !w_inuse) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_v   = r_ov;
    assign o_tag = r_otag;
    assign o_sid = r_osid;
    assign c_v   = r_cv;
    assign c_sid = r_csid;
    assign c_tag = r_ctag;
    assign o_err = r_err;
endmodule

// File: tb/tb_l2_req_issue.sv
// Self-checking bench for l2_req_issue: directed scenarios followed by random
// traffic, all compared against a tag-ownership reference model.
module tb_l2_req_issue;
    import l2_pkg::*;

    logic            clk;
    logic            reset;
    logic            i_v;
    logic            i_r;
    logic [SIDW-1:0] i_sel;
    logic            o_v;
    logic            o_r;
    logic [TAGW-1:0] o_tag;
    logic [SIDW-1:0] o_sid;
    logic            rsp_v;
    logic [TAGW-1:0] rsp_tag;
    logic            c_v;
    logic [SIDW-1:0] c_sid;
    logic [TAGW-1:0] c_tag;
    logic [WAYS-1:0] o_busy;
    logic [TAGW:0]   o_free;
    logic            o_err;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: owner[t] is the stream holding tag t, or -1 when free.
    int owner [TAGS];
    bit mOv;
    int mTag, mSid;
    bit mCv;
    int mCsid, mCtag;
    bit mErr;

    l2_req_issue dut (
        .clk    (clk),
        .reset  (reset),
        .i_v    (i_v),
        .i_r    (i_r),
        .i_sel  (i_sel),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_tag  (o_tag),
        .o_sid  (o_sid),
        .rsp_v  (rsp_v),
        .rsp_tag(rsp_tag),
        .c_v    (c_v),
        .c_sid  (c_sid),
        .c_tag  (c_tag),
        .o_busy (o_busy),
        .o_free (o_free),
        .o_err  (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int outstanding(input int s);
        int n = 0;
        for (int t = 0; t < TAGS; t++) if (owner[t] == s) n++;
        return n;
    endfunction

    function automatic int lowestFree();
        for (int t = 0; t < TAGS; t++) if (owner[t] < 0) return t;
        return -1;
    endfunction

    function automatic int freeCount();
        int n = 0;
        for (int t = 0; t < TAGS; t++) if (owner[t] < 0) n++;
        return n;
    endfunction

    function automatic bit modelReady(input int sel, input bit ordy);
        return (freeCount() > 0) && (outstanding(sel) < MAXOUT) && (!mOv || ordy);
    endfunction

    task automatic modelReset();
        for (int t = 0; t < TAGS; t++) owner[t] = -1;
        mOv = 0; mTag = 0; mSid = 0;
        mCv = 0; mCsid = 0; mCtag = 0;
        mErr = 0;
    endtask

    task automatic modelClock(input bit v, input int sel, input bit ordy, input bit rv, input int rtag);
        bit acc;
        bit ok;
        int cand;
        acc  = v && modelReady(sel, ordy);
        cand = lowestFree();
        ok   = rv && (owner[rtag] >= 0);
        mCv  = ok;
        if (ok) begin
            mCsid = owner[rtag];
            mCtag = rtag;
            owner[rtag] = -1;
        end
        if (rv && !ok) mErr = 1;
        if (acc) begin
            owner[cand] = sel;
            mOv = 1; mTag = cand; mSid = sel;
        end else if (ordy) begin
            mOv = 0;
        end
    endtask

    task automatic checkAll();
        logic [31:0] busy;
        busy = '0;
        for (int s = 0; s < WAYS; s++) busy[s] = (outstanding(s) == MAXOUT);
        checkOutput("o_v", 32'(o_v), 32'(mOv));
        checkOutput("o_tag", 32'(o_tag), 32'(mTag));
        checkOutput("o_sid", 32'(o_sid), 32'(mSid));
        checkOutput("c_v", 32'(c_v), 32'(mCv));
        checkOutput("c_sid", 32'(c_sid), 32'(mCsid));
        checkOutput("c_tag", 32'(c_tag), 32'(mCtag));
        checkOutput("o_busy", 32'(o_busy), busy);
        checkOutput("o_free", 32'(o_free), 32'(freeCount()));
        checkOutput("o_err", 32'(o_err), 32'(mErr));
    endtask

    task automatic applyStimulus(input bit v, input int sel, input bit ordy, input bit rv, input int rtag);
        i_v     = v;
        i_sel   = SIDW'(sel);
        o_r     = ordy;
        rsp_v   = rv;
        rsp_tag = TAGW'(rtag);
    endtask

    // One clock: drive after the falling edge, check ready, then check registered outputs.
    task automatic step(input bit v, input int sel, input bit ordy, input bit rv, input int rtag);
        applyStimulus(v, sel, ordy, rv, rtag);
        #1;
        checkOutput("i_r", 32'(i_r), 32'(modelReady(sel, ordy)));
        modelClock(v, sel, ordy, rv, rtag);
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset();
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkAll();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        modelReset();
        doReset();

        for (int k = 0; k < 4; k++) step(1, 5, 1, 0, 0);
        checkOutput("tag3", 32'(o_tag), 32'd3);
        checkOutput("busy5", 32'(o_busy[5]), 32'd1);
        step(1, 5, 1, 0, 0);
        step(1, 6, 1, 0, 0);

        doReset();
        for (int k = 0; k < TAGS; k++) step(1, k % 8, 1, 0, 0);
        checkOutput("free0", 32'(o_free), 32'd0);
        step(1, 3, 1, 1, 17);
        checkOutput("c_tag17", 32'(c_tag), 32'd17);
        step(1, 1, 1, 0, 0);
        checkOutput("realloc17", 32'(o_tag), 32'd17);

        doReset();
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);

        doReset();
        for (int k = 0; k < 4; k++) step(1, 2, 1, 0, 0);
        step(1, 2, 1, 1, 0);
        step(1, 2, 1, 0, 0);

        step(0, 0, 1, 1, 9);
        step(0, 0, 1, 0, 0);
        checkOutput("err_sticky", 32'(o_err), 32'd1);
        doReset();
        step(0, 0, 1, 1, 1);

        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 699) doReset();
            step($urandom_range(0, 9) < 8, $urandom_range(0, WAYS - 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
                 $urandom_range(0, TAGS - 1));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
